// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline hazard controller.
// State encodings, field widths and the hard-wired zero register index.
package pipe_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int REG_W  = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  localparam logic [REG_W-1:0] R0_IDX = '0;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter for pipeline performance statistics.
// Holds at all-ones instead of wrapping.
module hazard_sat_counter
  import pipe_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: dmem handshake, branch redirect, load-use.
// Priority is memory stall, then taken branch, then load-use.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int R0_ZERO  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_W-1:0]  ex1_rd,
  input  logic              ex1_mem_read,
  input  logic [REG_W-1:0]  ex2_rd,
  input  logic              ex2_mem_read,
  input  logic              mem_branch,
  input  logic              mem_branch_ne,
  input  logic              mem_zero,
  input  logic [DATA_W-1:0] mem_branch_target,
  input  logic              mem_mem_read,
  input  logic              mem_mem_write,
  input  logic              dmem_ack,
  output logic              dmem_req,
  output logic              pc_stall,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target,
  output logic              stall_if_id,
  output logic              stall_id_ex1,
  output logic              stall_ex1_ex2,
  output logic              stall_ex2_mem,
  output logic              flush_if_id,
  output logic              flush_id_ex1,
  output logic              flush_ex1_ex2,
  output logic              flush_mem,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT - 1);

  state_t     state, state_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic       tmo_nx;

  logic mem_op, taken, tmo_release, mem_stall, hz;
  logic act_mem, act_br, act_lu;

  function automatic logic hit(
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs
  );
    return (rd == rs) && !((R0_ZERO != 0) && (rd == R0_IDX));
  endfunction

  assign mem_op = mem_mem_read | mem_mem_write;
  assign taken  = ~mem_op &
                  ((mem_branch & mem_zero) |
                   (mem_branch_ne & ~mem_zero));

  assign tmo_release = (state == WAIT) && (wait_cnt == WAIT_LIM);
  assign mem_stall   = mem_op & ~dmem_ack & ~tmo_release;

  assign hz =
    (ex1_mem_read &
     ((id_uses_rs1 & hit(ex1_rd, id_rs1)) |
      (id_uses_rs2 & hit(ex1_rd, id_rs2)))) |
    (ex2_mem_read &
     ((id_uses_rs1 & hit(ex2_rd, id_rs1)) |
      (id_uses_rs2 & hit(ex2_rd, id_rs2))));

  assign act_mem = rst_n & mem_stall;
  assign act_br  = rst_n & ~mem_stall & taken;
  assign act_lu  = rst_n & ~mem_stall & ~taken & hz;

  assign dmem_req = rst_n & mem_op;

  always_comb begin
    pc_stall      = 1'b0;
    pc_load       = 1'b0;
    pc_target     = '0;
    stall_if_id   = 1'b0;
    stall_id_ex1  = 1'b0;
    stall_ex1_ex2 = 1'b0;
    stall_ex2_mem = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex1  = 1'b0;
    flush_ex1_ex2 = 1'b0;
    flush_mem     = 1'b0;
    unique case (1'b1)
      act_mem: begin
        pc_stall      = 1'b1;
        stall_if_id   = 1'b1;
        stall_id_ex1  = 1'b1;
        stall_ex1_ex2 = 1'b1;
        stall_ex2_mem = 1'b1;
      end
      act_br: begin
        pc_load       = 1'b1;
        pc_target     = mem_branch_target;
        flush_if_id   = 1'b1;
        flush_id_ex1  = 1'b1;
        flush_ex1_ex2 = 1'b1;
        flush_mem     = 1'b1;
      end
      act_lu: begin
        pc_stall     = 1'b1;
        stall_if_id  = 1'b1;
        flush_id_ex1 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    tmo_nx   = mem_timeout;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          state_nx = WAIT;
          wait_nx  = '0;
        end
      end
      WAIT: begin
        if (mem_stall) begin
          wait_nx = wait_cnt + 8'd1;
        end else begin
          state_nx = RUN;
          // The access is abandoned as complete on expiry.
          if (mem_op & ~dmem_ack & tmo_release)
            tmo_nx = 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_nx;
      mem_timeout <= tmo_nx;
    end
  end

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_stall),
    .count (stall_count)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_load),
    .count (flush_count)
  );

endmodule
